// File: rtl/alu_pkg.sv
// Shared opcode constants, datapath width and arbiter FSM state type.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int W = 16;

  localparam logic [3:0] NOOP  = 4'b0000;
  localparam logic [3:0] ADD   = 4'b0001;
  localparam logic [3:0] SUB   = 4'b0010;
  localparam logic [3:0] MULT  = 4'b0011;
  localparam logic [3:0] DIV   = 4'b0100;
  localparam logic [3:0] AND   = 4'b0101;
  localparam logic [3:0] OR    = 4'b0110;
  localparam logic [3:0] XOR   = 4'b0111;
  localparam logic [3:0] NOT   = 4'b1000;
  localparam logic [3:0] RESET = 4'b1111;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_t;

  // Opcodes 1001..1110 have no ALU meaning and are bounced by the arbiter.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= NOT) || (op == RESET);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant from request valids and the last served id.
// Latency: purely combinational, last_grant is held by the parent.
// Backpressure: none; grant is only a suggestion until the parent accepts.
module rr_arb2 (
  input  logic [1:0] req_vld,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt_id
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = 1'b0;
    if (req_vld == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req_vld[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one accumulator ALU between two requesters; optional ALU_ARB_DIVCHK_EN traps DIV by zero.
// Latency: accept -> 1 EXEC cycle -> response 2 cycles after accept (1 cycle for rejected requests).
// Backpressure: single outstanding request; response held stable until rsp_ready, no accepts meanwhile.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         clear_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_err,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  input  logic [W-1:0] alu_out
);

  arb_state_t   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         id_q, id_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] result_q, result_d;
  logic         err_q, err_d;

  logic         gnt_vld;
  logic         gnt_id;
  logic [3:0]   gnt_op;
  logic [W-1:0] gnt_a;
  logic [W-1:0] gnt_b;
  logic         gnt_reject;
  logic [W-1:0] reject_data;

  rr_arb2 u_rr_arb2 (
    .req_vld    ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  // Select the granted payload and decide whether it bypasses the ALU.
  always_comb begin
    gnt_op      = gnt_id ? req1_op : req0_op;
    gnt_a       = gnt_id ? req1_a  : req0_a;
    gnt_b       = gnt_id ? req1_b  : req0_b;
    gnt_reject  = !op_is_legal(gnt_op);
    reject_data = '0;
`ifdef ALU_ARB_DIVCHK_EN
    if ((gnt_op == DIV) && (gnt_b == '0)) begin
      gnt_reject  = 1'b1;
      reject_data = '1;
    end
`endif
  end

  // Next-state logic, request accept and result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    err_d        = err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (gnt_vld) begin
          req0_ready = !gnt_id;
          req1_ready = gnt_id;
          id_d       = gnt_id;
          op_d       = gnt_op;
          a_d        = gnt_a;
          b_d        = gnt_b;
          if (gnt_reject) begin
            // Rejected requests never touch the ALU, so the turn is consumed here.
            result_d     = reject_data;
            err_d        = 1'b1;
            last_grant_d = gnt_id;
            state_d      = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d     = alu_out;
        last_grant_d = id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // ALU drive and response channels, decoded from the current state.
  always_comb begin
    alu_op     = NOOP;
    alu_in1    = '0;
    alu_in2    = '0;
    rsp0_valid = 1'b0;
    rsp0_data  = '0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_data  = '0;
    rsp1_err   = 1'b0;
    case (state_q)
      ST_INIT: alu_op = RESET;
      ST_EXEC: begin
        alu_op  = op_q;
        alu_in1 = a_q;
        alu_in2 = b_q;
      end
      ST_RESP: begin
        if (id_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_q;
          rsp1_err   = err_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_q;
          rsp0_err   = err_q;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= ST_INIT;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= NOOP;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an accumulator ALU stand-in and a cycle reference model.
// Latency: n/a.
// Backpressure: rsp_ready is driven both directed and random.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [15:0] rsp0_data, rsp1_data;
  logic [3:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_out, acc_q;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .clear_n(clear_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
  );

  // Stand-in accumulator ALU: alu_out is the next accumulator value.
  always_comb begin
    case (alu_op)
      ADD:     alu_out = alu_in1 + alu_in2;
      SUB:     alu_out = alu_in1 - alu_in2;
      MULT:    alu_out = alu_in1 * alu_in2;
      DIV:     alu_out = alu_in1 / alu_in2;
      AND:     alu_out = alu_in1 & alu_in2;
      OR:      alu_out = alu_in1 | alu_in2;
      XOR:     alu_out = alu_in1 ^ alu_in2;
      NOT:     alu_out = ~alu_in1;
      RESET:   alu_out = 16'h0000;
      default: alu_out = acc_q;
    endcase
  end
  always @(posedge clk) acc_q <= alu_out;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: one transaction in flight at most.
  bit          m_init = 1'b1;
  bit          m_busy = 1'b0;
  bit          m_exec_pending;
  bit          m_id;
  bit          m_err;
  bit          m_known;
  bit          m_last = 1'b1;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_data;
  logic [15:0] m_acc = 16'h0;
  bit          m_acc_known = 1'b1;
  bit          acc_evt[2];
  int          grants[$];

  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] acc);
    logic [31:0] prod;
    prod = 32'(a) * 32'(b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return prod[15:0];
      4'd4:    return a / b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return ~a;
      4'd15:   return 16'h0000;
      default: return acc;
    endcase
  endfunction

  // Compare every output against the model, then advance the model across the next edge.
  task automatic model_cycle();
    int          g;
    bit          legal;
    logic [3:0]  e_op;
    logic [15:0] e1, e2;
    bit          ev0, ev1;
    if (!clear_n) begin
      chk("rst_req0_ready", 32'(req0_ready), 0);
      chk("rst_req1_ready", 32'(req1_ready), 0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
      chk("rst_rsp0_err", 32'(rsp0_err), 0);
      chk("rst_rsp1_err", 32'(rsp1_err), 0);
      chk("rst_rsp0_data", 32'(rsp0_data), 0);
      chk("rst_rsp1_data", 32'(rsp1_data), 0);
      chk("rst_alu_op", 32'(alu_op), 32'hF);
      chk("rst_alu_in", 32'({alu_in1, alu_in2}), 0);
      m_init = 1; m_busy = 0; m_last = 1; m_acc = 0; m_acc_known = 1;
    end else begin
      g = -1;
      if (!m_init && !m_busy) begin
        if (req0_valid && req1_valid) g = m_last ? 0 : 1;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      e_op = 4'h0; e1 = 0; e2 = 0;
      if (m_init) e_op = 4'hF;
      else if (m_busy && m_exec_pending) begin e_op = m_op; e1 = m_a; e2 = m_b; end
      ev0 = m_busy && !m_exec_pending && !m_id;
      ev1 = m_busy && !m_exec_pending && m_id;
      chk("req0_ready", 32'(req0_ready), 32'(g == 0));
      chk("req1_ready", 32'(req1_ready), 32'(g == 1));
      chk("alu_op", 32'(alu_op), 32'(e_op));
      chk("alu_in1", 32'(alu_in1), 32'(e1));
      chk("alu_in2", 32'(alu_in2), 32'(e2));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
      if (ev0) begin
        chk("rsp0_err", 32'(rsp0_err), 32'(m_err));
        if (m_known) chk("rsp0_data", 32'(rsp0_data), 32'(m_data));
      end
      if (ev1) begin
        chk("rsp1_err", 32'(rsp1_err), 32'(m_err));
        if (m_known) chk("rsp1_data", 32'(rsp1_data), 32'(m_data));
      end
      if (m_init) begin
        m_init = 0; m_acc = 0; m_acc_known = 1;
      end else if (m_busy) begin
        if (m_exec_pending) begin
          m_exec_pending = 0; m_acc = m_data; m_acc_known = m_known;
        end else if (m_id ? rsp1_ready : rsp0_ready) begin
          m_busy = 0;
        end
      end else if (g >= 0) begin
        grants.push_back(g);
        acc_evt[g] = 1;
        m_last = (g == 1); m_id = (g == 1); m_busy = 1;
        m_op = m_id ? req1_op : req0_op;
        m_a  = m_id ? req1_a : req0_a;
        m_b  = m_id ? req1_b : req0_b;
        legal = (m_op <= 4'd8) || (m_op == 4'd15);
        if (!legal) begin
          m_data = 0; m_err = 1; m_known = 1; m_exec_pending = 0;
`ifdef ALU_ARB_DIVCHK_EN
        end else if (m_op == 4'd4 && m_b == 0) begin
          m_data = 16'hFFFF; m_err = 1; m_known = 1; m_exec_pending = 0;
`endif
        end else begin
          m_data = ref_result(m_op, m_a, m_b, m_acc);
          m_err = 0; m_exec_pending = 1;
          if (m_op == 4'd0) m_known = m_acc_known;
          else m_known = !(m_op == 4'd4 && m_b == 0);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (i == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic rand_req(input int i);
    logic [3:0]  op;
    logic [15:0] a, b;
    op = 4'($urandom_range(0, 15));
    a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
    b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
`ifndef ALU_ARB_DIVCHK_EN
    if (op == 4'd4 && b == 0) b = 16'd1;
`endif
    set_req(i, op, a, b);
  endtask

  task automatic wait_accept(input int i, input int bound);
    int n = 0;
    while (!acc_evt[i] && n < bound) begin step(); n++; end
    chk("accept_timeout", 32'(acc_evt[i]), 1);
    acc_evt[i] = 0;
    if (i == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    do begin step(); n++; end while (m_busy && n < bound);
    chk("idle_timeout", 32'(m_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    clear_n = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) step();
    clear_n = 1;
    step();                                   // the single INIT cycle drives RESET

    // ADD 1+1 from requester 0, response two cycles after accept.
    set_req(0, ADD, 16'd1, 16'd1);
    wait_accept(0, 5);
    chk("add_exec_op", 32'(alu_op), 32'(ADD));
    chk("add_exec_rsp_early", 32'(rsp0_valid), 0);
    step();
    chk("add_rsp_valid", 32'(rsp0_valid), 1);
    chk("add_rsp_data", 32'(rsp0_data), 2);
    chk("add_rsp_err", 32'(rsp0_err), 0);
    run_until_idle(5);

    // Both requesters hold valid: grants must alternate.
    grants.delete();
    set_req(0, MULT, 16'd2, 16'd2);
    set_req(1, SUB, 16'd3, 16'd1);
    for (int n = 0; n < 60 && grants.size() < 8; n++) step();
    req0_valid = 0; req1_valid = 0;
    run_until_idle(5);
    acc_evt[0] = 0; acc_evt[1] = 0;
    chk("rr_grant_count", 32'(grants.size()), 8);
    zeros = 0;
    for (int k = 0; k < grants.size(); k++) begin
      if (grants[k] == 0) zeros++;
      if (k > 0) chk("rr_alternate", 32'(grants[k]), 32'(grants[k-1] == 0));
    end
    chk("rr_no_starve", 32'(zeros), 4);

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 0;
    set_req(1, XOR, 16'd11, 16'd13);
    wait_accept(1, 5);
    set_req(0, NOOP, 16'd0, 16'd0);
    step();
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_valid", 32'(rsp1_valid), 1);
      chk("bp_data", 32'(rsp1_data), 6);
      chk("bp_req0_ready", 32'(req0_ready), 0);
    end
    rsp1_ready = 1;
    step();
    chk("bp_idle_reentry", 32'(req0_ready), 1);
    wait_accept(0, 3);
    run_until_idle(5);

    // Illegal opcode: immediate rejection, ALU untouched.
    set_req(0, 4'b1010, 16'd3, 16'd4);
    wait_accept(0, 5);
    chk("ill_rsp_valid", 32'(rsp0_valid), 1);
    chk("ill_rsp_err", 32'(rsp0_err), 1);
    chk("ill_rsp_data", 32'(rsp0_data), 0);
    chk("ill_alu_op", 32'(alu_op), 32'(NOOP));
    run_until_idle(5);

    // Division, including by zero.
    set_req(0, DIV, 16'd8, 16'd2);
    wait_accept(0, 5);
    step();
    chk("div_data", 32'(rsp0_data), 4);
    run_until_idle(5);
    set_req(0, DIV, 16'd8, 16'd0);
    wait_accept(0, 5);
`ifdef ALU_ARB_DIVCHK_EN
    chk("div0_data", 32'(rsp0_data), 32'hFFFF);
    chk("div0_err", 32'(rsp0_err), 1);
`else
    step();
    chk("div0_err", 32'(rsp0_err), 0);
`endif
    run_until_idle(5);
    set_req(0, NOOP, 16'd0, 16'd0);
    wait_accept(0, 5);
    step();
`ifdef ALU_ARB_DIVCHK_EN
    chk("div0_acc_kept", 32'(rsp0_data), 4);
`endif
    run_until_idle(5);
    set_req(0, RESET, 16'd0, 16'd0);
    wait_accept(0, 5);
    run_until_idle(5);

    // Reset pulse while the request is in EXEC.
    set_req(0, ADD, 16'd5, 16'd6);
    wait_accept(0, 5);
    clear_n = 0;
    #1;
    chk("mid_rst_alu_op", 32'(alu_op), 32'(RESET));
    chk("mid_rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("mid_rst_req0_ready", 32'(req0_ready), 0);
    step();
    step();
    clear_n = 1;
    for (int n = 0; n < 4; n++) step();

    // Random traffic against the model.
    acc_evt[0] = 0; acc_evt[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_evt[i]) begin
          acc_evt[i] = 0;
          if ($urandom_range(0, 1) == 1) rand_req(i);
          else if (i == 0) req0_valid = 0;
          else req1_valid = 0;
        end else if (!(i == 0 ? req0_valid : req1_valid) && $urandom_range(0, 3) == 0) begin
          rand_req(i);
        end
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    run_until_idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
